// File: rtl/phase_cmd_sched.sv
// phase_cmd_sched
//   Arbitrates operator commands from the IR key decoder and the UART byte
//   receiver, decodes them into per-channel phase writes and the array output
//   enable, and keeps a shadow copy of every channel phase so relative IR steps
//   can be applied. Phase writes leave over a req/ack handshake with a timeout.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   ir_stb, ir_code     1-cycle strobe + IR key code
//   uart_stb, uart_byte 1-cycle strobe + received UART byte
//   cfg_wr/addr/data    phase write request, held until cfg_ack or timeout
//   cfg_ack             generator accepted the write
//   out_en              array output enable
//   sel_ch              channel selected by IR up/down
//   busy                high while a write is outstanding
//   err                 sticky ack-timeout flag
//   drop_cnt            saturating count of commands lost to full slots
module phase_cmd_sched #(
  parameter int         NCH    = 8,
  parameter int         AW     = 3,
  parameter logic [7:0] STEP   = 8'd4,
  parameter int         TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ir_stb,
  input  logic [7:0]    ir_code,
  input  logic          uart_stb,
  input  logic [7:0]    uart_byte,
  output logic          cfg_wr,
  output logic [AW-1:0] cfg_addr,
  output logic [7:0]    cfg_data,
  input  logic          cfg_ack,
  output logic          out_en,
  output logic [AW-1:0] sel_ch,
  output logic          busy,
  output logic          err,
  output logic [7:0]    drop_cnt
);

  localparam logic [7:0]    IR_UP    = 8'h18;
  localparam logic [7:0]    IR_DOWN  = 8'h52;
  localparam logic [7:0]    IR_RIGHT = 8'h5A;
  localparam logic [7:0]    IR_LEFT  = 8'h08;
  localparam logic [7:0]    IR_OK    = 8'h1C;
  localparam logic [7:0]    U_ON     = 8'hE1;
  localparam logic [7:0]    U_OFF    = 8'hE0;
  localparam logic [AW-1:0] CH_MAX   = AW'(NCH - 1);
  localparam logic [15:0]   TO_LAST  = 16'(TO_CYC - 1);

  typedef enum logic { S_IDLE, S_WRITE } state_t;
  typedef enum logic { U_HDR, U_DAT } ustate_t;

  state_t        state_q, state_d;
  ustate_t       ustate_q, ustate_d;
  logic          ir_full_q, ir_full_d;
  logic [7:0]    ir_slot_q, ir_slot_d;
  logic          uart_full_q, uart_full_d;
  logic [7:0]    uart_slot_q, uart_slot_d;
  logic          rr_ir_q, rr_ir_d;
  logic [AW-1:0] uch_q, uch_d;
  logic [AW-1:0] sel_ch_q, sel_ch_d;
  logic [AW-1:0] cfg_addr_q, cfg_addr_d;
  logic [7:0]    cfg_data_q, cfg_data_d;
  logic          cfg_wr_q, cfg_wr_d;
  logic          out_en_q, out_en_d;
  logic          err_q, err_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [15:0]   tmr_q, tmr_d;
  logic [7:0]    shadow_q [NCH];
  logic [7:0]    shadow_d [NCH];

  logic          grant_ir, grant_uart, ir_drop, uart_drop;
  logic [8:0]    drop_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ustate_q    <= U_HDR;
      ir_full_q   <= 1'b0;
      ir_slot_q   <= '0;
      uart_full_q <= 1'b0;
      uart_slot_q <= '0;
      rr_ir_q     <= 1'b1;
      uch_q       <= '0;
      sel_ch_q    <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_wr_q    <= 1'b0;
      out_en_q    <= 1'b0;
      err_q       <= 1'b0;
      drop_cnt_q  <= '0;
      tmr_q       <= '0;
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ustate_q    <= ustate_d;
      ir_full_q   <= ir_full_d;
      ir_slot_q   <= ir_slot_d;
      uart_full_q <= uart_full_d;
      uart_slot_q <= uart_slot_d;
      rr_ir_q     <= rr_ir_d;
      uch_q       <= uch_d;
      sel_ch_q    <= sel_ch_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_wr_q    <= cfg_wr_d;
      out_en_q    <= out_en_d;
      err_q       <= err_d;
      drop_cnt_q  <= drop_cnt_d;
      tmr_q       <= tmr_d;
      shadow_q    <= shadow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ustate_d    = ustate_q;
    ir_full_d   = ir_full_q;
    ir_slot_d   = ir_slot_q;
    uart_full_d = uart_full_q;
    uart_slot_d = uart_slot_q;
    rr_ir_d     = rr_ir_q;
    uch_d       = uch_q;
    sel_ch_d    = sel_ch_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    cfg_wr_d    = cfg_wr_q;
    out_en_d    = out_en_q;
    err_d       = err_q;
    tmr_d       = tmr_q;
    shadow_d    = shadow_q;
    grant_ir    = 1'b0;
    grant_uart  = 1'b0;
    ir_drop     = 1'b0;
    uart_drop   = 1'b0;

    // Round-robin pointer only moves when both sources contend.
    if (state_q == S_IDLE) begin
      if (ir_full_q && uart_full_q) begin
        grant_ir   = rr_ir_q;
        grant_uart = !rr_ir_q;
        rr_ir_d    = !rr_ir_q;
      end else begin
        grant_ir   = ir_full_q;
        grant_uart = uart_full_q;
      end
    end

    // A strobe in the same cycle as its slot's grant simply refills the slot.
    if (ir_stb) begin
      if (ir_full_q && !grant_ir) ir_drop = 1'b1;
      else begin
        ir_full_d = 1'b1;
        ir_slot_d = ir_code;
      end
    end else if (grant_ir) begin
      ir_full_d = 1'b0;
    end

    if (uart_stb) begin
      if (uart_full_q && !grant_uart) uart_drop = 1'b1;
      else begin
        uart_full_d = 1'b1;
        uart_slot_d = uart_byte;
      end
    end else if (grant_uart) begin
      uart_full_d = 1'b0;
    end

    drop_sum   = {1'b0, drop_cnt_q} + 9'(ir_drop) + 9'(uart_drop);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    if (grant_ir) begin
      case (ir_slot_q)
        IR_UP:   sel_ch_d = (sel_ch_q == CH_MAX) ? '0 : sel_ch_q + AW'(1);
        IR_DOWN: sel_ch_d = (sel_ch_q == '0) ? CH_MAX : sel_ch_q - AW'(1);
        IR_RIGHT, IR_LEFT: begin
          cfg_addr_d = sel_ch_q;
          cfg_data_d = (ir_slot_q == IR_RIGHT) ? shadow_q[sel_ch_q] + STEP
                                               : shadow_q[sel_ch_q] - STEP;
          cfg_wr_d   = 1'b1;
          tmr_d      = '0;
          state_d    = S_WRITE;
        end
        IR_OK:   out_en_d = !out_en_q;
        default: ;
      endcase
    end

    // The UART parser advances only on UART grants, so IR traffic between a
    // header and its data byte leaves it untouched.
    if (grant_uart) begin
      if (ustate_q == U_HDR) begin
        if ((uart_slot_q[7:4] == 4'hA) && ({28'd0, uart_slot_q[3:0]} < 32'(NCH))) begin
          uch_d    = uart_slot_q[AW-1:0];
          ustate_d = U_DAT;
        end else if (uart_slot_q == U_ON) begin
          out_en_d = 1'b1;
        end else if (uart_slot_q == U_OFF) begin
          out_en_d = 1'b0;
        end
      end else begin
        cfg_addr_d = uch_q;
        cfg_data_d = uart_slot_q;
        cfg_wr_d   = 1'b1;
        tmr_d      = '0;
        state_d    = S_WRITE;
        ustate_d   = U_HDR;
      end
    end

    // Shadow is only committed on a real ack; a timed-out write leaves it.
    if (state_q == S_WRITE) begin
      if (cfg_ack) begin
        shadow_d[cfg_addr_q] = cfg_data_q;
        cfg_wr_d             = 1'b0;
        state_d              = S_IDLE;
      end else if (tmr_q == TO_LAST) begin
        cfg_wr_d = 1'b0;
        err_d    = 1'b1;
        state_d  = S_IDLE;
      end else begin
        tmr_d = tmr_q + 16'd1;
      end
    end
  end

  assign cfg_wr   = cfg_wr_q;
  assign cfg_addr = cfg_addr_q;
  assign cfg_data = cfg_data_q;
  assign out_en   = out_en_q;
  assign sel_ch   = sel_ch_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_phase_cmd_sched.sv
// Testbench for phase_cmd_sched: scenario tasks with a transaction-level
// reference model of channel selection, shadow phases and the UART parser.
module tb_phase_cmd_sched;

  localparam int         NCH  = 8;
  localparam int         AW   = 3;
  localparam int         TO   = 16;
  localparam logic [7:0] STEP = 8'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ir_stb = 1'b0;
  logic [7:0]    ir_code = '0;
  logic          uart_stb = 1'b0;
  logic [7:0]    uart_byte = '0;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_data;
  logic          cfg_ack = 1'b0;
  logic          out_en;
  logic [AW-1:0] sel_ch;
  logic          busy;
  logic          err;
  logic [7:0]    drop_cnt;

  phase_cmd_sched #(.NCH(NCH), .AW(AW), .STEP(STEP), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ir_stb(ir_stb), .ir_code(ir_code),
    .uart_stb(uart_stb), .uart_byte(uart_byte), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .out_en(out_en), .sel_ch(sel_ch), .busy(busy), .err(err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int hang_cnt = 0;

  // reference model
  logic [7:0] m_shadow [NCH];
  int         m_sel;
  bit         m_out_en;
  bit         m_uhdr;
  int         m_uch;
  bit         m_rr_ir;

  // ack responder: 0 never, 1 always, 2 random short delay, 3 fixed delay
  int ack_mode = 0;
  int ack_delay = 3;
  int wr_age = 0;
  int rdelay = 0;

  // write monitor
  int         obs_a [$];
  logic [7:0] obs_d [$];
  int         obs_len [$];
  int         wr_len = 0;
  int         hold_a = 0;
  logic [7:0] hold_d = '0;
  int         to_cnt = 0;
  int         to_len = 0;
  int         to_a = 0;
  logic [7:0] to_d = '0;
  int         unstable_cnt = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (cfg_wr) wr_age++; else wr_age = 0;
      if (cfg_wr && wr_age == 1) rdelay = $urandom_range(0, 4);
      case (ack_mode)
        1:       cfg_ack = 1'b1;
        2:       cfg_ack = cfg_wr && (wr_age > rdelay);
        3:       cfg_ack = cfg_wr && (wr_age >= ack_delay);
        default: cfg_ack = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_len = 0;
      end else if (cfg_wr) begin
        if (wr_len > 0 && (int'(cfg_addr) != hold_a || cfg_data !== hold_d)) unstable_cnt++;
        hold_a = int'(cfg_addr);
        hold_d = cfg_data;
        wr_len++;
        if (cfg_ack) begin
          obs_a.push_back(hold_a);
          obs_d.push_back(hold_d);
          obs_len.push_back(wr_len);
          wr_len = 0;
        end
      end else if (wr_len > 0) begin
        to_cnt++;
        to_len = wr_len;
        to_a = hold_a;
        to_d = hold_d;
        wr_len = 0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic obs_clear();
    obs_a.delete(); obs_d.delete(); obs_len.delete();
  endtask

  task automatic send(input bit use_ir, input bit use_uart,
                      input logic [7:0] ic, input logic [7:0] ub);
    ir_code = ic; uart_byte = ub; ir_stb = use_ir; uart_stb = use_uart;
    tick();
    ir_stb = 1'b0; uart_stb = 1'b0;
  endtask

  // Waits until the block has been idle for 3 consecutive cycles.
  task automatic settle();
    int idle_run = 0;
    int n = 0;
    while (idle_run < 3 && n < 400) begin
      tick(); n++;
      if (!busy) idle_run++; else idle_run = 0;
    end
    if (n >= 400) hang_cnt++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
    m_sel = 0; m_out_en = 0; m_uhdr = 1; m_uch = 0; m_rr_ir = 1;
  endtask

  task automatic model_ir(input logic [7:0] code, output bit w, output int a, output logic [7:0] d);
    w = 0; a = 0; d = '0;
    case (code)
      8'h18: m_sel = (m_sel + 1) % NCH;
      8'h52: m_sel = (m_sel + NCH - 1) % NCH;
      8'h5A: begin w = 1; a = m_sel; d = m_shadow[m_sel] + STEP; end
      8'h08: begin w = 1; a = m_sel; d = m_shadow[m_sel] - STEP; end
      8'h1C: m_out_en = !m_out_en;
      default: ;
    endcase
  endtask

  task automatic model_uart(input logic [7:0] b, output bit w, output int a, output logic [7:0] d);
    w = 0; a = 0; d = '0;
    if (m_uhdr) begin
      if (b[7:4] == 4'hA && int'(b[3:0]) < NCH) begin m_uch = int'(b[3:0]); m_uhdr = 0; end
      else if (b == 8'hE1) m_out_en = 1;
      else if (b == 8'hE0) m_out_en = 0;
    end else begin
      w = 1; a = m_uch; d = b; m_uhdr = 1;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (cfg_wr !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_wr got=%b exp=0", cfg_wr); end
    n_cmp++; if (cfg_addr !== 3'd0 || cfg_data !== 8'd0) begin n_fail++; $display("FAIL reset_cfg_bus got=%0d/%h exp=0/00", cfg_addr, cfg_data); end
    n_cmp++; if (out_en !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got out_en=%b busy=%b err=%b exp=0", out_en, busy, err); end
    n_cmp++; if (sel_ch !== 3'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_counters got sel=%0d drop=%0d exp=0", sel_ch, drop_cnt); end
  endtask

  task automatic test_ir_step_wrap();
    bit w; int a; logic [7:0] d;
    ack_mode = 1;
    for (int i = 0; i < 64; i++) begin
      model_ir(8'h5A, w, a, d);
      obs_clear(); send(1, 0, 8'h5A, 8'h00); settle();
      n_cmp++;
      if (obs_a.size() != 1) begin n_fail++; $display("FAIL ir_step_count i=%0d got=%0d exp=1", i, obs_a.size()); end
      else if (obs_a[0] != a || obs_d[0] !== d || obs_len[0] != 1) begin
        n_fail++; $display("FAIL ir_step i=%0d got=%0d/%h len=%0d exp=%0d/%h len=1", i, obs_a[0], obs_d[0], obs_len[0], a, d);
      end else if ((i == 0 && obs_d[0] !== 8'h04) || (i == 63 && obs_d[0] !== 8'h00)) begin
        n_fail++; $display("FAIL ir_step_edge i=%0d got=%h", i, obs_d[0]);
      end
      m_shadow[a] = d;
    end
  endtask

  task automatic test_uart_write();
    bit w; int a; logic [7:0] d;
    ack_mode = 1;
    obs_clear();
    model_uart(8'hA3, w, a, d); send(0, 1, 8'h00, 8'hA3); settle();
    model_uart(8'h7F, w, a, d); send(0, 1, 8'h00, 8'h7F); settle();
    n_cmp++;
    if (obs_a.size() != 1) begin n_fail++; $display("FAIL uart_write_count got=%0d exp=1", obs_a.size()); end
    else if (obs_a[0] != 3 || obs_d[0] !== 8'h7F) begin n_fail++; $display("FAIL uart_write got=%0d/%h exp=3/7f", obs_a[0], obs_d[0]); end
    m_shadow[a] = d;
    for (int i = 0; i < 3; i++) begin model_ir(8'h18, w, a, d); send(1, 0, 8'h18, 8'h00); settle(); end
    n_cmp++; if (int'(sel_ch) != m_sel || m_sel != 3) begin n_fail++; $display("FAIL sel_up got=%0d exp=3", sel_ch); end
    obs_clear();
    model_ir(8'h08, w, a, d); send(1, 0, 8'h08, 8'h00); settle();
    n_cmp++;
    if (obs_a.size() != 1) begin n_fail++; $display("FAIL ir_left_count got=%0d exp=1", obs_a.size()); end
    else if (obs_a[0] != 3 || obs_d[0] !== 8'h7B) begin n_fail++; $display("FAIL ir_left got=%0d/%h exp=3/7b", obs_a[0], obs_d[0]); end
    m_shadow[a] = d;
  endtask

  task automatic test_arbitration();
    bit w; int a; logic [7:0] d;
    int ea [2]; logic [7:0] ed [2];
    ack_mode = 3; ack_delay = 3;
    for (int r = 0; r < 2; r++) begin
      model_uart(8'hA2, w, a, d); send(0, 1, 8'h00, 8'hA2); settle();
      if (m_rr_ir) begin
        model_ir(8'h5A, w, ea[0], ed[0]); m_shadow[ea[0]] = ed[0];
        model_uart(8'h33 + 8'(r), w, ea[1], ed[1]); m_shadow[ea[1]] = ed[1];
      end else begin
        model_uart(8'h33 + 8'(r), w, ea[0], ed[0]); m_shadow[ea[0]] = ed[0];
        model_ir(8'h5A, w, ea[1], ed[1]); m_shadow[ea[1]] = ed[1];
      end
      m_rr_ir = !m_rr_ir;
      obs_clear(); send(1, 1, 8'h5A, 8'h33 + 8'(r)); settle();
      n_cmp++;
      if (obs_a.size() != 2) begin n_fail++; $display("FAIL arb_count r=%0d got=%0d exp=2", r, obs_a.size()); end
      else begin
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (obs_a[k] != ea[k] || obs_d[k] !== ed[k] || obs_len[k] != 3) begin
            n_fail++; $display("FAIL arb_order r=%0d k=%0d got=%0d/%h len=%0d exp=%0d/%h len=3", r, k, obs_a[k], obs_d[k], obs_len[k], ea[k], ed[k]);
          end
        end
        n_cmp++;
        if (obs_a[0] != ((r == 0) ? 3 : 2)) begin n_fail++; $display("FAIL arb_first r=%0d got_addr=%0d exp=%0d", r, obs_a[0], (r == 0) ? 3 : 2); end
      end
    end
  endtask

  task automatic test_out_en();
    bit w; int a; logic [7:0] d;
    ack_mode = 1;
    model_uart(8'hE1, w, a, d); send(0, 1, 8'h00, 8'hE1); settle();
    n_cmp++; if (out_en !== 1'b1) begin n_fail++; $display("FAIL uart_on got=%b exp=1", out_en); end
    model_ir(8'h1C, w, a, d); send(1, 0, 8'h1C, 8'h00); settle();
    n_cmp++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL ir_ok got=%b exp=0", out_en); end
    obs_clear();
    model_uart(8'hA9, w, a, d); send(0, 1, 8'h00, 8'hA9); settle();
    model_uart(8'h55, w, a, d); send(0, 1, 8'h00, 8'h55); settle();
    n_cmp++; if (obs_a.size() != 0 || to_cnt != 0) begin n_fail++; $display("FAIL bad_hdr got_writes=%0d exp=0", obs_a.size()); end
  endtask

  task automatic test_random();
    bit w; int a; logic [7:0] d; bit src_ir; int pick; logic [7:0] v;
    ack_mode = 2;
    for (int i = 0; i < 60; i++) begin
      src_ir = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      if (src_ir) begin
        case (pick)
          0, 1: v = 8'h18;  2: v = 8'h52;  3, 4: v = 8'h5A;
          5, 6: v = 8'h08;  7: v = 8'h1C;  default: v = 8'($urandom);
        endcase
        model_ir(v, w, a, d);
      end else begin
        case (pick)
          0, 1, 2, 3: v = 8'hA0 | 8'($urandom_range(0, 15));
          4: v = 8'hE1;  5: v = 8'hE0;  default: v = 8'($urandom);
        endcase
        model_uart(v, w, a, d);
      end
      obs_clear(); send(src_ir, !src_ir, v, v); settle();
      n_cmp++;
      if (obs_a.size() != int'(w)) begin n_fail++; $display("FAIL rand_count i=%0d code=%h got=%0d exp=%0d", i, v, obs_a.size(), w); end
      else if (w && (obs_a[0] != a || obs_d[0] !== d)) begin n_fail++; $display("FAIL rand_write i=%0d got=%0d/%h exp=%0d/%h", i, obs_a[0], obs_d[0], a, d); end
      if (w) m_shadow[a] = d;
      n_cmp++;
      if (int'(sel_ch) != m_sel || out_en !== m_out_en) begin n_fail++; $display("FAIL rand_state i=%0d got sel=%0d en=%b exp sel=%0d en=%b", i, sel_ch, out_en, m_sel, m_out_en); end
    end
  endtask

  task automatic test_timeout_stall();
    bit w; int a; logic [7:0] d; int ta; logic [7:0] td; int to0;
    ack_mode = 1;
    for (int i = 0; i < NCH && m_sel != 0; i++) begin model_ir(8'h18, w, a, d); send(1, 0, 8'h18, 8'h00); settle(); end
    ack_mode = 0; obs_clear(); to0 = to_cnt;
    model_ir(8'h5A, w, ta, td);
    send(1, 0, 8'h5A, 8'h00); tick();
    send(1, 0, 8'h52, 8'h00); model_ir(8'h52, w, a, d);
    send(1, 0, 8'h18, 8'h00);
    send(1, 0, 8'h18, 8'h00);
    settle();
    n_cmp++; if (to_cnt != to0 + 1 || to_len != TO) begin n_fail++; $display("FAIL timeout_len got=%0d cnt=%0d exp=%0d", to_len, to_cnt - to0, TO); end
    n_cmp++; if (to_a != ta || to_d !== td || obs_a.size() != 0) begin n_fail++; $display("FAIL timeout_write got=%0d/%h exp=%0d/%h", to_a, to_d, ta, td); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=2", drop_cnt); end
    n_cmp++; if (int'(sel_ch) != m_sel || m_sel != 7) begin n_fail++; $display("FAIL sel_down_wrap got=%0d exp=7", sel_ch); end
    ack_mode = 1;
    model_ir(8'h18, w, a, d); send(1, 0, 8'h18, 8'h00); settle();
    obs_clear(); model_ir(8'h5A, w, a, d); send(1, 0, 8'h5A, 8'h00); settle();
    n_cmp++;
    if (obs_a.size() != 1) begin n_fail++; $display("FAIL after_to_count got=%0d exp=1", obs_a.size()); end
    else if (obs_a[0] != a || obs_d[0] !== d || obs_d[0] !== td) begin n_fail++; $display("FAIL after_to got=%0d/%h exp=%0d/%h", obs_a[0], obs_d[0], a, d); end
    m_shadow[a] = d;
  endtask

  task automatic test_drop_sat();
    bit w; int a; logic [7:0] d;
    ack_mode = 1;
    if (!m_uhdr) begin model_uart(8'h00, w, a, d); send(0, 1, 8'h00, 8'h00); settle(); m_shadow[a] = d; end
    ir_code = 8'h00; uart_byte = 8'h00; ir_stb = 1'b1; uart_stb = 1'b1;
    repeat (300) tick();
    ir_stb = 1'b0; uart_stb = 1'b0;
    settle();
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
  endtask

  task automatic test_reset_midwrite();
    bit w; int a; logic [7:0] d;
    ack_mode = 0;
    send(1, 0, 8'h5A, 8'h00); tick();
    n_cmp++; if (cfg_wr !== 1'b1) begin n_fail++; $display("FAIL midwrite_pre got=%b exp=1", cfg_wr); end
    #2 rst = 1'b0; #1;
    n_cmp++; if (cfg_wr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset got wr=%b busy=%b exp=0", cfg_wr, busy); end
    n_cmp++; if (err !== 1'b0 || drop_cnt !== 8'd0 || sel_ch !== 3'd0 || out_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got err=%b drop=%0d sel=%0d en=%b exp=0", err, drop_cnt, sel_ch, out_en);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ack_mode = 1; obs_clear();
    model_ir(8'h5A, w, a, d); send(1, 0, 8'h5A, 8'h00); settle();
    n_cmp++;
    if (obs_a.size() != 1) begin n_fail++; $display("FAIL post_reset_count got=%0d exp=1", obs_a.size()); end
    else if (obs_a[0] != 0 || obs_d[0] !== 8'h04 || obs_d[0] !== d) begin n_fail++; $display("FAIL post_reset got=%0d/%h exp=0/04", obs_a[0], obs_d[0]); end
  endtask

  task automatic test_integrity();
    n_cmp++; if (hang_cnt != 0) begin n_fail++; $display("FAIL settle_bound got=%0d exp=0", hang_cnt); end
    n_cmp++; if (unstable_cnt != 0) begin n_fail++; $display("FAIL cfg_stable got=%0d exp=0", unstable_cnt); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    tick();
    test_reset();
    test_ir_step_wrap();
    test_uart_write();
    test_arbitration();
    test_out_en();
    test_random();
    test_timeout_stall();
    test_drop_sat();
    test_reset_midwrite();
    test_integrity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
